// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A packed hex word and per-digit decimal points are captured into shadow
//   registers on a load strobe. The digits are then scanned one at a time, and
//   each nibble is decoded to active-low segments. Every digit slot starts with
//   one dark cycle so that the previous digit's pattern does not ghost onto the
//   next digit. Leading zeros can optionally be blanked.
//
// Parameters
//   NUM_DIGITS  number of digits scanned (>= 1)
//   CLK_DIV     clk cycles per digit slot (>= 2); the first cycle is dark
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   value     in   packed hex digits, digit k = value[4k+3:4k], digit 0 = LS
//   dp        in   decimal-point request per digit, 1 = lit
//   load      in   1-cycle strobe that captures value/dp into the shadow
//   blank_lz  in   1 = suppress leading zeros (used live, not shadowed)
//   segment   out  {g,f,e,d,c,b,a}, active-low, registered
//   dp_n      out  decimal point, active-low, registered
//   digit_n   out  one-hot active-low digit enables, registered
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              segment,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_n
);

  // A single-digit build still needs a 1-bit index register.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF = 7'h7F;

  // ---------------------------------------------------------------------------
  // Hex-to-segment decode, active-low {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h20;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow registers: live inputs only reach the display through a load.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  //       register samples pre-edge values regardless of the order of the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counters: pre_cnt walks through one digit slot, idx picks the digit.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_pre_cnt;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_idx     <= '0;
    end else if (r_pre_cnt == CNT_MAX) begin
      r_pre_cnt <= '0;
      r_idx     <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detect: w_zero_from[k] = every shadow nibble k..N-1 is zero.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_zero_from;

  // NOTE: every always_comb output gets a default before any branch or loop so
  //       that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    logic w_acc;
    w_zero_from = '0;
    w_acc       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc          = w_acc & (r_shadow_val[4*k +: 4] == 4'h0);
      w_zero_from[k] = w_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit select: nibble, decimal point, blank flag, one-hot enable.
  // ---------------------------------------------------------------------------
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_lz;
  logic [NUM_DIGITS-1:0] w_digit_sel;

  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_lz        = 1'b0;
    w_digit_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib          = r_shadow_val[4*k +: 4];
        w_dp_sel       = r_shadow_dp[k];
        // Digit 0 is never blanked, so an all-zero word still shows "0".
        w_lz           = w_zero_from[k] && (k > 0);
        w_digit_sel[k] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: lags the counters by one cycle. The first cycle of each
  // slot (pre_cnt == 0) is dark, which gives the anti-ghosting gap.
  // ---------------------------------------------------------------------------
  logic [6:0]            r_segment;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_digit_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segment <= SEG_OFF;
      r_dp_n    <= 1'b1;
      r_digit_n <= '1;
    end else if (r_pre_cnt == '0) begin
      r_segment <= SEG_OFF;
      r_dp_n    <= 1'b1;
      r_digit_n <= '1;
    end else begin
      // A blanked leading zero still drives its enable and decimal point.
      r_segment <= (blank_lz && w_lz) ? SEG_OFF : decode_hex(w_nib);
      r_dp_n    <= ~w_dp_sel;
      r_digit_n <= ~w_digit_sel;
    end
  end

  assign segment = r_segment;
  assign dp_n    = r_dp_n;
  assign digit_n = r_digit_n;

endmodule
